// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver, 8N1, LSB first, mid-bit sampling.
// Latency: o_data/o_rxne update on the stop-sample edge, 152*(i_div+1)+3 clk after the pin falls.
// Backpressure: none; an unread byte is overwritten by the next good byte and o_overrun is raised.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_div,
  input  logic        i_rx,
  input  logic        i_rd_ack,
  output logic [7:0]  o_data,
  output logic        o_rxne,
  output logic        o_frame_err,
  output logic        o_overrun,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Mid-bit is the 8th tick after the falling edge; full bit is 16 ticks.
  localparam logic [3:0] MID_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] END_SAMPLE = 4'(OVERSAMPLE - 1);

  logic        rx_meta;
  logic        rx_s;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] tc;
  logic [3:0]  sc;
  logic [2:0]  bc;
  logic [7:0]  shreg;
  logic        tick;
  logic        mid_tick;
  logic        end_tick;
  logic        moving;
  logic        stop_done;
  logic        frame_good;
  logic        frame_bad;

  // '>=' rather than '==' so a divisor shrunk mid-frame cannot strand tc above it.
  assign tick       = (state != S_IDLE) && (tc >= i_div);
  assign mid_tick   = tick && (sc == MID_SAMPLE);
  assign end_tick   = tick && (sc == END_SAMPLE);
  assign moving     = (state_nxt != state);
  assign stop_done  = i_en && (state == S_STOP) && end_tick;
  assign frame_good = stop_done && rx_s;
  assign frame_bad  = stop_done && !rx_s;
  assign o_busy     = (state != S_IDLE);

  // Two-flop synchroniser for the asynchronous pin, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state selection; disabling the receiver always wins.
  always_comb begin
    state_nxt = state;
    if (!i_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (!rx_s) state_nxt = S_START;
        S_START: if (mid_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (end_tick && (bc == 3'd7)) state_nxt = S_STOP;
        S_STOP:  if (end_tick) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tick and sample counters restart on each state change so sampling is phase-locked to the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 16'd0;
      sc <= 4'd0;
    end else if (moving || (state == S_IDLE)) begin
      tc <= 16'd0;
      sc <= 4'd0;
    end else if (tick) begin
      tc <= 16'd0;
      sc <= sc + 4'd1;
    end else begin
      tc <= tc + 16'd1;
    end
  end

  // Data bits enter at bit 7 and shift right, leaving the first bit in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc    <= 3'd0;
      shreg <= 8'd0;
    end else if ((state == S_DATA) && end_tick) begin
      bc    <= bc + 3'd1;
      shreg <= {rx_s, shreg[7:1]};
    end else if (state != S_DATA) begin
      bc    <= 3'd0;
    end
  end

  // Output byte and status flags; a read acknowledge clears flags but never hides a byte landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data      <= 8'h00;
      o_rxne      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (frame_good) begin
        o_data <= shreg;
        o_rxne <= 1'b1;
      end else if (i_rd_ack) begin
        o_rxne <= 1'b0;
      end

      if (frame_good && o_rxne && !i_rd_ack) begin
        o_overrun <= 1'b1;
      end else if (i_rd_ack) begin
        o_overrun <= 1'b0;
      end

      if (frame_bad) begin
        o_frame_err <= 1'b1;
      end else if (i_rd_ack) begin
        o_frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: frame-level reference model plus per-cycle output comparison.
// Expected results come from frame start times and the receiver's timing and flag rules.
// Directed scenarios first, then randomized frames, divisors and acknowledge timing.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [15:0] i_div;
  logic        i_rx;
  logic        i_rd_ack;
  logic [7:0]  o_data;
  logic        o_rxne;
  logic        o_frame_err;
  logic        o_overrun;
  logic        o_busy;

  uart_rx_core #(.OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_div       (i_div),
    .i_rx        (i_rx),
    .i_rd_ack    (i_rd_ack),
    .o_data      (o_data),
    .o_rxne      (o_rxne),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  // Reference model state.
  logic [7:0] m_data = 8'h00;
  bit         m_rxne = 1'b0;
  bit         m_fe   = 1'b0;
  bit         m_ov   = 1'b0;
  int         ev_kind = 0;   // 0 none, 1 good byte, 2 bad stop
  int         ev_edge = -1;
  logic [7:0] ev_byte = 8'h00;
  int         b_start = 0, b_end = 0, b2_start = 0, b2_end = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      if (n_errors > 50) begin
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Model: applies each frame's outcome at its computed stop-sample edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        m_data = 8'h00; m_rxne = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        ev_kind = 0; b_end = cyc; b2_end = cyc;
      end else if (ev_kind != 0 && cyc == ev_edge) begin
        if (ev_kind == 1) begin
          if (i_rd_ack) m_ov = 1'b0;
          else if (m_rxne) m_ov = 1'b1;
          if (i_rd_ack) m_fe = 1'b0;
          m_rxne = 1'b1;
          m_data = ev_byte;
        end else begin
          m_fe = 1'b1;
          if (i_rd_ack) begin m_rxne = 1'b0; m_ov = 1'b0; end
        end
        ev_kind = 0;
      end else if (i_rd_ack) begin
        m_rxne = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      end
    end
  end

  // Compare all outputs against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        bit exp_busy;
        exp_busy = (cyc >= b_start && cyc < b_end) || (cyc >= b2_start && cyc < b2_end);
        check("outputs{data,rxne,fe,ov,busy}",
              32'({o_data, o_rxne, o_frame_err, o_overrun, o_busy}),
              32'({m_data, m_rxne, m_fe, m_ov, exp_busy}));
      end
    end
  end

  // Drive one 8N1 frame with bit time 16*d clk and register its expected outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int d);
    int n;
    n = cyc;
    ev_byte = b;
    ev_kind = stop ? 1 : 2;
    ev_edge = n + 3 + 152 * d;
    b_start = n + 3;
    b_end   = ev_edge;
    if (stop) begin
      b2_start = 0; b2_end = 0;
    end else begin
      // Low stop bit still on the pin after the stop sample: a short false start follows.
      b2_start = ev_edge + 1; b2_end = ev_edge + 1 + 8 * d;
    end
    i_rx = 1'b0;
    step(16 * d);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      step(16 * d);
    end
    i_rx = stop;
    step(16 * d);
    i_rx = 1'b1;
  endtask

  task automatic send_glitch(input int width, input int d);
    int n;
    n = cyc;
    ev_kind = 0;
    b_start = n + 3; b_end = n + 3 + 8 * d;
    b2_start = 0; b2_end = 0;
    i_rx = 1'b0;
    step(width);
    i_rx = 1'b1;
    step(16 * d);
  endtask

  task automatic pulse_ack();
    i_rd_ack = 1'b1;
    step(1);
    i_rd_ack = 1'b0;
  endtask

  // Acknowledge sampled at edge number tgt.
  task automatic ack_at(input int tgt);
    step(tgt - 1 - cyc);
    pulse_ack();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n, w, d, gap, mode, tgt;
    logic [7:0] b;
    bit st;

    rst = 1'b1; i_en = 1'b0; i_div = 16'd14; i_rx = 1'b1; i_rd_ack = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    check("reset_data",  32'(o_data),      32'h00);
    check("reset_rxne",  32'(o_rxne),      32'h0);
    check("reset_fe",    32'(o_frame_err), 32'h0);
    check("reset_ov",    32'(o_overrun),   32'h0);
    check("reset_busy",  32'(o_busy),      32'h0);
    chk_on = 1'b1;
    i_en = 1'b1;
    step(5);

    // One byte, exact latency 152*15+3 = 2283 clk after the pin falls.
    fork
      send_frame(8'h55, 1'b1, 15);
      begin
        step(2282);
        check("lat_rxne_before", 32'(o_rxne), 32'h0);
        step(1);
        check("lat_rxne_at",  32'(o_rxne), 32'h1);
        check("lat_data_at",  32'(o_data), 32'h55);
        check("lat_fe",       32'(o_frame_err), 32'h0);
        check("lat_ov",       32'(o_overrun),   32'h0);
      end
    join
    step(20);
    pulse_ack();
    check("ack_clears_rxne", 32'(o_rxne), 32'h0);

    // Glitch rejection.
    fork
      send_glitch(60, 15);
      begin
        step(10);
        check("glitch_busy", 32'(o_busy), 32'h1);
      end
    join
    check("glitch_idle", 32'(o_busy), 32'h0);
    check("glitch_rxne", 32'(o_rxne), 32'h0);
    check("glitch_fe",   32'(o_frame_err), 32'h0);

    // Framing error after a good byte.
    send_frame(8'h3C, 1'b1, 15);
    send_frame(8'hA5, 1'b0, 15);
    step(16 * 15);
    check("ferr_flag", 32'(o_frame_err), 32'h1);
    check("ferr_data", 32'(o_data),      32'h3C);
    check("ferr_rxne", 32'(o_rxne),      32'h1);
    pulse_ack();
    check("ferr_cleared", 32'(o_frame_err), 32'h0);

    // Overrun from back-to-back frames, then acknowledge.
    send_frame(8'h12, 1'b1, 15);
    send_frame(8'h34, 1'b1, 15);
    step(5);
    check("ovr_data", 32'(o_data),    32'h34);
    check("ovr_rxne", 32'(o_rxne),    32'h1);
    check("ovr_flag", 32'(o_overrun), 32'h1);
    pulse_ack();
    check("ovr_ack_rxne", 32'(o_rxne),    32'h0);
    check("ovr_ack_flag", 32'(o_overrun), 32'h0);

    // Acknowledge coinciding with the stop-sample edge.
    send_frame(8'h12, 1'b1, 15);
    n = cyc;
    fork
      send_frame(8'h34, 1'b1, 15);
      ack_at(n + 3 + 152 * 15);
    join
    check("coin_rxne", 32'(o_rxne),    32'h1);
    check("coin_data", 32'(o_data),    32'h34);
    check("coin_ov",   32'(o_overrun), 32'h0);

    // Reset during data bit 3 (pin high from there on), then a clean frame.
    fork
      send_frame(8'hF8, 1'b1, 15);
      begin
        step(16 * 15 * 4 + 8 * 15);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_data", 32'(o_data), 32'h00);
        check("rst_rxne", 32'(o_rxne), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
      end
    join
    step(10);
    send_frame(8'hC3, 1'b1, 15);
    check("after_rst_data", 32'(o_data), 32'hC3);
    check("after_rst_rxne", 32'(o_rxne), 32'h1);
    pulse_ack();

    // Disable mid-frame.
    fork
      send_frame(8'h5A, 1'b1, 15);
      begin
        step(40 * 15);
        i_en = 1'b0;
        ev_kind = 0;
        b_end = cyc + 1;
        step(1);
        check("dis_busy", 32'(o_busy), 32'h0);
      end
    join
    step(20);
    i_en = 1'b1;
    check("dis_rxne", 32'(o_rxne), 32'h0);
    step(5);

    // Randomized frames, divisors and acknowledge timing.
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(2, 6);
      i_div = 16'(d - 1);
      b = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) != 0);
      mode = $urandom_range(0, 2);
      n = cyc;
      if (mode == 1 && st) tgt = n + 3 + 152 * d;
      else tgt = n + 3 + $urandom_range(10, 150 * d);
      fork
        send_frame(b, st, d);
        if (mode != 0) ack_at(tgt);
      join
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
      if (!st) gap = gap + 16 * d;
      step(gap);
    end
    step(10);

    // Divisor change mid-frame must not lock the receiver.
    chk_on = 1'b0;
    i_div = 16'd14;
    fork
      send_frame(8'hFF, 1'b1, 15);
      begin
        step(16 * 15 * 2);
        i_div = 16'd2;
        w = 0;
        while (o_busy && w < 160 * 3 + 20) begin
          step(1);
          w++;
        end
        check("div_change_idle", 32'(o_busy), 32'h0);
      end
    join
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    chk_on = 1'b1;
    send_frame(8'h96, 1'b1, 3);
    step(5);
    check("div_recover_data", 32'(o_data), 32'h96);
    check("div_recover_rxne", 32'(o_rxne), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
